// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 DVP capture front end.
// Holds the capture FSM states, RGB565 byte lanes and a counter-width helper.
package ov5640_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    ACTIVE  = 2'd3
  } cam_state_e;

  // RGB565 arrives MSB-first: bytes 0..2 of a pair wait in a 24-bit holding
  // register at these offsets, byte 3 is appended straight from the input.
  localparam int HOLD_B0_LSB = 16;
  localparam int HOLD_B1_LSB = 8;
  localparam int HOLD_B2_LSB = 0;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Registers the DVP inputs once and derives href/vsync-blanking edges from
// the registered copies; vsync is folded so that "blank" always means blanking.
module cmos_sync_edge #(
  parameter bit VS_ACTIVE_HI = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       href_o,
  output logic       href_rise_o,
  output logic       href_fall_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o
);

  logic       vs_q, vs_prev_q;
  logic       href_q, href_prev_q;
  logic [7:0] data_q;
  logic       blank, blank_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      vs_q        <= vsync_i;
      vs_prev_q   <= vs_q;
      href_q      <= href_i;
      href_prev_q <= href_q;
      data_q      <= data_i;
    end
  end

  // Both copies share one fold, so reset never produces a false blanking edge.
  assign blank      = VS_ACTIVE_HI ? vs_q      : ~vs_q;
  assign blank_prev = VS_ACTIVE_HI ? vs_prev_q : ~vs_prev_q;

  assign data_o      = data_q;
  assign href_o      = href_q;
  assign href_rise_o = href_q & ~href_prev_q;
  assign href_fall_o = ~href_q & href_prev_q;
  assign vs_rise_o   = blank & ~blank_prev;
  assign vs_fall_o   = ~blank & blank_prev;

endmodule

// File: rtl/cmos_frame_packer.sv
// OV5640 DVP to DDR write-FIFO front end: skips start-up frames, aligns to a
// frame boundary, packs RGB565 byte pairs into 32-bit words and flags bad frames.
module cmos_frame_packer
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int SKIP_FRAMES  = 10,
  parameter bit VS_ACTIVE_HI = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output cam_state_e  dbg_state_o
);

  localparam int BW = cnt_w(2 * H_ACTIVE);
  localparam int LW = cnt_w(V_ACTIVE);
  localparam int SW = cnt_w(SKIP_FRAMES);
  localparam logic [BW-1:0] LINE_BYTES = BW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] V_LINES    = LW'(V_ACTIVE);
  localparam logic [SW-1:0] SKIP_LAST  = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  logic [7:0] data_r;
  logic       href_r, href_rise, href_fall, vs_rise, vs_fall;

  cmos_sync_edge #(.VS_ACTIVE_HI(VS_ACTIVE_HI)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_i     (cam_vsync),
    .href_i      (cam_href),
    .data_i      (cam_data),
    .data_o      (data_r),
    .href_o      (href_r),
    .href_rise_o (href_rise),
    .href_fall_o (href_fall),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall)
  );

  cam_state_e    state_q;
  logic [SW-1:0] skip_cnt_q;
  logic [BW-1:0] byte_cnt_q;
  logic          over_q;
  logic [LW-1:0] line_cnt_q;
  logic          line_bad_q;
  logic          started_q;
  logic [23:0]   hold_q;
  logic          wr_en_q, frame_start_q, frame_done_q, frame_err_q;
  logic [31:0]   wr_data_q;
  logic [15:0]   frame_cnt_q;

  // The byte phase restarts on every href rise, so the rising cycle counts as byte 0.
  logic [BW-1:0] cur_cnt;
  logic [1:0]    phase;
  logic          at_limit, pack_ok, line_end_bad;

  assign cur_cnt      = href_rise ? '0 : byte_cnt_q;
  assign phase        = cur_cnt[1:0];
  assign at_limit     = (cur_cnt == LINE_BYTES);
  assign pack_ok      = href_r && !at_limit && (line_cnt_q != V_LINES);
  assign line_end_bad = (byte_cnt_q != LINE_BYTES) || over_q || (line_cnt_q == V_LINES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      skip_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      over_q        <= 1'b0;
      line_cnt_q    <= '0;
      line_bad_q    <= 1'b0;
      started_q     <= 1'b0;
      hold_q        <= 24'h0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 32'h0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 16'h0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      if (!init_done) begin
        state_q    <= IDLE;
        skip_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            skip_cnt_q <= '0;
            state_q    <= SKIP;
          end
          SKIP: begin
            if (SKIP_FRAMES == 0) begin
              state_q <= WAIT_VS;
            end else if (vs_rise) begin
              if (skip_cnt_q == SKIP_LAST) state_q <= WAIT_VS;
              else                         skip_cnt_q <= skip_cnt_q + 1'b1;
            end
          end
          WAIT_VS: begin
            if (vs_fall) begin
              state_q    <= ACTIVE;
              line_cnt_q <= '0;
              line_bad_q <= 1'b0;
              started_q  <= 1'b0;
              byte_cnt_q <= '0;
              over_q     <= 1'b0;
            end
          end
          ACTIVE: begin
            if (vs_rise) begin
              // A line still in progress when blanking starts is a short line.
              frame_done_q <= 1'b1;
              frame_err_q  <= line_bad_q || (line_cnt_q != V_LINES) || href_r;
              frame_cnt_q  <= frame_cnt_q + 16'h1;
              state_q      <= WAIT_VS;
            end else begin
              if (href_rise && !started_q) begin
                frame_start_q <= 1'b1;
                started_q     <= 1'b1;
              end
              if (href_r) begin
                byte_cnt_q <= at_limit ? cur_cnt : cur_cnt + 1'b1;
                over_q     <= (href_rise ? 1'b0 : over_q) | at_limit;
                if (pack_ok) begin
                  case (phase)
                    2'd0: hold_q[HOLD_B0_LSB +: 8] <= data_r;
                    2'd1: hold_q[HOLD_B1_LSB +: 8] <= data_r;
                    2'd2: hold_q[HOLD_B2_LSB +: 8] <= data_r;
                    default: begin
                      wr_en_q   <= 1'b1;
                      wr_data_q <= {hold_q, data_r};
                    end
                  endcase
                end
              end
              if (href_fall) begin
                if (line_cnt_q != V_LINES) line_cnt_q <= line_cnt_q + 1'b1;
                if (line_end_bad)          line_bad_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Self-checking bench for cmos_frame_packer: frame-level reference model with
// expected-word and expected-frame queues fed by randomized DVP frames.
module tb_cmos_frame_packer;
  import ov5640_pkg::*;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int SKIP = 1;

  localparam int M_OFF   = 0;
  localparam int M_SKIP  = 1;
  localparam int M_ARMED = 2;
  localparam int M_CAP   = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        wr_en, frame_start, frame_done, frame_err;
  logic [31:0] wr_data;
  logic [15:0] frame_cnt;
  cam_state_e  dbg_state;

  always #5 clk = ~clk;

  cmos_frame_packer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP), .VS_ACTIVE_HI(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_done_q[$];
  int          exp_starts = 0;
  int          seen_starts = 0;
  int          mode = M_OFF;
  int          skip_cnt = 0;
  logic [15:0] m_cnt = 16'h0;
  int          f_len[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) check("wr_en_unexpected", {31'b0, wr_en}, 32'd0);
        else                   check("wr_data", wr_data, exp_q.pop_front());
      end
      if (frame_done) begin
        if (exp_done_q.size() == 0) check("frame_done_unexpected", {31'b0, frame_done}, 32'd0);
        else check("frame_done_err_cnt", {15'b0, frame_err, frame_cnt}, exp_done_q.pop_front());
      end
      if (frame_start) seen_starts++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_wr_en", {31'b0, wr_en}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_pulses", {29'b0, frame_start, frame_done, frame_err}, 32'd0);
      check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mode     = init_done ? ((SKIP == 0) ? M_ARMED : M_SKIP) : M_OFF;
    skip_cnt = 0;
    m_cnt    = 16'h0;
  endtask

  // One frame: active region (vsync low) with the lines in f_len, then blanking.
  // ev_kind 1 drops init_done, 2 pulses reset, just before byte ev_byte of line ev_line.
  task automatic send_frame(input int ev_kind, input int ev_line, input int ev_byte, input bit seq);
    bit          cap;
    bit          err;
    bit          stopped;
    int          bidx;
    logic [7:0]  b;
    logic [31:0] w;
    stopped = 1'b0;
    bidx    = 0;
    w       = 32'h0;
    if (!init_done) begin
      init_done = 1'b1;
      mode      = (SKIP == 0) ? M_ARMED : M_SKIP;
      skip_cnt  = 0;
    end
    tick(2);
    cam_vsync = 1'b0;
    cap = (mode == M_ARMED);
    if (cap) mode = M_CAP;
    err = (f_len.size() != V);
    tick($urandom_range(3, 6));
    for (int l = 0; l < f_len.size(); l++) begin
      if (f_len[l] != 2 * H) err = 1'b1;
      for (int k = 0; k < f_len[l]; k++) begin
        if (!stopped && ev_kind != 0 && l == ev_line && k == ev_byte) begin
          stopped = 1'b1;
          if (ev_kind == 1) begin
            init_done = 1'b0;
            mode      = M_OFF;
          end else begin
            do_reset();
          end
        end
        b = seq ? 8'(bidx) : 8'($urandom);
        bidx++;
        cam_href = 1'b1;
        cam_data = b;
        if (cap && !stopped && l < V && k < 2 * H) begin
          w = {w[23:0], b};
          if (k % 4 == 3) exp_q.push_back(w);
          if (l == 0 && k == 0) exp_starts++;
        end
        tick(1);
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      tick($urandom_range(2, 4));
    end
    cam_vsync = 1'b1;
    if (mode == M_CAP) begin
      m_cnt = m_cnt + 16'h1;
      exp_done_q.push_back({15'b0, err, m_cnt});
      mode = M_ARMED;
    end else if (mode == M_SKIP) begin
      skip_cnt++;
      if (skip_cnt >= SKIP) mode = M_ARMED;
    end
    tick($urandom_range(3, 6));
  endtask

  task automatic set_lines(input int a, input int b, input int c);
    f_len.delete();
    if (a > 0) f_len.push_back(a);
    if (b > 0) f_len.push_back(b);
    if (c > 0) f_len.push_back(c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    set_lines(8, 8, 0);  send_frame(0, 0, 0, 1'b0);
    send_frame(0, 0, 0, 1'b1);
    tick(4);
    check("cnt_after_first", {16'b0, frame_cnt}, {16'b0, m_cnt});
    check("state_after_first", {30'b0, dbg_state}, {30'b0, WAIT_VS});

    send_frame(2, 1, 2, 1'b0);
    check("cnt_after_reset", {16'b0, frame_cnt}, 32'd0);
    send_frame(0, 0, 0, 1'b0);

    set_lines(8, 10, 0); send_frame(0, 0, 0, 1'b0);
    set_lines(6, 8, 0);  send_frame(0, 0, 0, 1'b0);
    set_lines(8, 8, 8);  send_frame(0, 0, 0, 1'b0);
    set_lines(8, 8, 0);  send_frame(0, 0, 0, 1'b0);

    send_frame(1, 0, 3, 1'b0);
    check("state_after_drop", {30'b0, dbg_state}, {30'b0, IDLE});
    send_frame(0, 0, 0, 1'b0);
    send_frame(0, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      f_len.delete();
      for (int j = 0; j < $urandom_range(1, 3); j++) f_len.push_back(2 * $urandom_range(2, 6));
      send_frame(0, 0, 0, 1'b0);
    end

    tick(10);
    check("words_left", exp_q.size(), 32'd0);
    check("frames_left", exp_done_q.size(), 32'd0);
    check("frame_starts", seen_starts, exp_starts);
    check("final_cnt", {16'b0, frame_cnt}, {16'b0, m_cnt});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
